sample_accumulator: RTL
=======================

# sample_accumulator

Downstream consumer of the 4→8-bit sign-extension stage. Accepts a stream of signed 8-bit samples over a valid/ready handshake and sums each block of `COUNT` consecutive samples into a wider signed accumulator with saturation. Presents one result per block on a valid/ready output port and holds it until taken. Sits between the sign extender and any block-level consumer, such as a decimator or register readout.

## Interface
Parameters:
- `IN_W`, 8, signed input sample width; matches the sign-extender output.
- `ACC_W`, 12, signed accumulator and result width; must be ≥ `IN_W`.
- `COUNT`, 4, samples per block; range 2..255.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `clear`  in  1  synchronous abort of the current block.
- `in_valid`  in  1  upstream sample valid.
- `in_ready`  out  1  block can accept a sample.
- `in_data`  in  `IN_W`  signed two's-complement sample.
- `out_valid`  out  1  block result valid.
- `out_ready`  in  1  downstream accepts the result.
- `out_sum`  out  `ACC_W`  signed saturated block sum.
- `out_ovf`  out  1  saturation occurred at least once in this block.

## Operation
- FSM has two states.
  - `ACCUM`: `in_ready`=1, `out_valid`=0.
  - `HOLD`: `in_ready`=0, `out_valid`=1.
- Sample accept: `in_valid && in_ready` in `ACCUM`.
  - `in_data` is sign-extended to `ACC_W` bits.
  - The value is added to `acc` through a saturating add.
  - `cnt` increments.
- Saturation clamps to +(2^(ACC_W-1)-1) or -(2^(ACC_W-1)).
  - `ovf` is sticky: it sets on any clamp within the block.
  - A clamped accumulator keeps accumulating. For example, a negative sample after a clamp to max pulls the sum back down.
- Block completion: the accept with `cnt == COUNT-1`.
  - Load `out_sum` ← sat(`acc` + sample) and `out_ovf` ← `ovf` | clamp_now.
  - Go to `HOLD`.
- In `HOLD`, `out_valid && out_ready` releases the result.
  - Go to `ACCUM` with `acc`=0, `cnt`=0, `ovf`=0.
- `out_sum` and `out_ovf` remain stable while `out_valid` is high and `out_ready` is low.
- `clear` has priority over every other event, in either state:
  - next state `ACCUM`; `acc`, `cnt`, `ovf` ← 0; `out_valid` ← 0.
  - Any pending result is discarded.
  - A sample presented in the same cycle is not accepted, because `in_ready` is low when `clear` is high.
- `in_ready` = (state == `ACCUM`) && !`clear`. It has no combinational dependence on `in_valid`.

## Timing
- Reset (`rst_n`=0, asynchronous): state `ACCUM`, `acc`=0, `cnt`=0, `ovf`=0, `out_sum`=0, `out_ovf`=0, `out_valid`=0, `in_ready`=1 once `clear`=0.
- Throughput in `ACCUM`: one sample per cycle.
- Latency: `out_valid` rises on the first edge after the `COUNT`-th accept.
- No bypass: the next block's first sample is accepted no earlier than the cycle after the output handshake. Minimum block period is therefore `COUNT`+1 cycles.
- When `in_valid` drops mid-block, `acc` and `cnt` hold.
- `rst_n` asserted mid-block or in `HOLD`: immediate return to reset values. The partial block is lost.
- `cnt` wraps only through completion, never by overflow.

## Structure
- Shared package `sample_acc_pkg` contains:
  - the state enum `{ACCUM, HOLD}`;
  - constant functions `sat_max(ACC_W)` and `sat_min(ACC_W)`;
  - the default width constants `IN_W`=8 and `ACC_W`=12.
- One sub-module, `sat_add`: combinational signed `ACC_W` + `ACC_W` → `ACC_W` adder with a `clamp` flag. Overflow detection uses operand and result sign bits.
- The top level holds the FSM, `cnt` (width clog2(`COUNT`)), `acc`, `ovf`, and the output registers.

## Test plan
- Reset and idle, defaults: release `rst_n` with no traffic → `in_ready`=1, `out_valid`=0, `out_sum`=0 indefinitely.
- Basic block, defaults: samples 3, -2 (0xFE), 7, -8 (0xF8), back-to-back → one cycle later `out_valid`=1, `out_sum`=0, `out_ovf`=0; `in_ready`=0 while held.
- Backpressure: complete a block of 1, 1, 1, 1 with `out_ready`=0 for 5 cycles → `out_sum`=4 stable and `in_ready`=0 throughout; `out_ready`=1 → `out_valid` drops and `in_ready`=1 on the next cycle.
- Saturation, `ACC_W`=8: samples 100, 100, -50, 10 → clamps at 127, then 77, then 87; `out_sum`=87, `out_ovf`=1. Negative case: -128 ×4 → `out_sum`=-128, `out_ovf`=1.
- Gaps and `clear`: 2 samples with idle gaps, then `clear` concurrent with `in_valid` → sample not accepted; the next 4 samples of 5 give `out_sum`=20. A `clear` in `HOLD` drops `out_valid` without a handshake.
- Reset mid-operation: `rst_n` asserted after 3 accepts, then released → a fresh 4-sample block of 1 gives `out_sum`=4, so no stale `acc` or `cnt` remains.

Source files
------------

// File: rtl/sample_acc_pkg.sv
// ---------------------------------------------------------------------------
// sample_acc_pkg
// Shared definitions for the sample accumulator slice.
//   - DEF_IN_W / DEF_ACC_W : default sample and accumulator widths
//   - acc_state_e          : block FSM states (collecting vs. holding result)
//   - sat_max / sat_min    : clamp limits of a signed word of a given width
// ---------------------------------------------------------------------------
package sample_acc_pkg;

  localparam int DEF_IN_W  = 8;
  localparam int DEF_ACC_W = 12;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } acc_state_e;

  // Largest positive value of a w-bit two's-complement word (w <= 31).
  function automatic int sat_max(input int w);
    return (2 ** (w - 1)) - 1;
  endfunction

  // Most negative value of a w-bit two's-complement word (w <= 31).
  function automatic int sat_min(input int w);
    return -(2 ** (w - 1));
  endfunction

endpackage

// File: rtl/sample_accumulator_if.sv
// ---------------------------------------------------------------------------
// sample_accumulator_if
// Bundles the streaming input handshake, the block-result handshake and the
// synchronous abort of the sample accumulator.
//   clear     : abort current block, discard pending result
//   in_valid  / in_ready / in_data            : sample stream
//   out_valid / out_ready / out_sum / out_ovf : block result
// master drives samples and takes results; slave is the accumulator.
// ---------------------------------------------------------------------------
interface sample_accumulator_if
  import sample_acc_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int ACC_W = DEF_ACC_W
);

  logic                    clear;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [IN_W-1:0]  in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [ACC_W-1:0] out_sum;
  logic                    out_ovf;

  modport master (
    output clear, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf
  );

  modport slave (
    input  clear, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sum, out_ovf
  );

endinterface

// File: rtl/sample_accumulator_sat_add.sv
// ---------------------------------------------------------------------------
// sat_add
// Combinational signed W + W -> W adder that clamps to the representable
// range instead of wrapping.
//   i_a, i_b : signed operands
//   o_sum    : saturated sum
//   o_clamp  : high when the true sum was out of range and got clamped
// ---------------------------------------------------------------------------
module sat_add
  import sample_acc_pkg::*;
#(
  parameter int W = DEF_ACC_W
) (
  input  logic signed [W-1:0] i_a,
  input  logic signed [W-1:0] i_b,
  output logic signed [W-1:0] o_sum,
  output logic                o_clamp
);

  localparam logic signed [W-1:0] MAX_V = W'(sat_max(W));
  localparam logic signed [W-1:0] MIN_V = W'(sat_min(W));

  logic signed [W-1:0] w_raw;
  logic                w_ovf;

  assign w_raw = i_a + i_b;

  // Overflow is only possible when both operands share a sign; it shows up
  // as the wrapped result carrying the opposite sign. The operand sign then
  // says which rail to clamp to.
  assign w_ovf   = (i_a[W-1] == i_b[W-1]) && (w_raw[W-1] != i_a[W-1]);
  assign o_sum   = w_ovf ? (i_a[W-1] ? MIN_V : MAX_V) : w_raw;
  assign o_clamp = w_ovf;

endmodule

// File: rtl/sample_accumulator.sv
// ---------------------------------------------------------------------------
// sample_accumulator
// Sums each block of COUNT signed samples into a saturating ACC_W-bit
// accumulator and presents one result per block, held until taken.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of sample_accumulator_if (samples in, results out,
//           synchronous clear)
// ---------------------------------------------------------------------------
module sample_accumulator
  import sample_acc_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int ACC_W = DEF_ACC_W,
  parameter int COUNT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sample_accumulator_if.slave  bus
);

  localparam int CNT_W = (COUNT > 2) ? $clog2(COUNT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(COUNT - 1);

  acc_state_e              r_state;
  acc_state_e              w_nextState;
  logic signed [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_ovf;
  logic signed [ACC_W-1:0] r_outSum;
  logic                    r_outOvf;

  logic signed [ACC_W-1:0] w_sample;
  logic signed [ACC_W-1:0] w_sum;
  logic                    w_clamp;
  logic                    w_inReady;
  logic                    w_accept;
  logic                    w_last;
  logic                    w_release;

  // Sample widened with sign extension before entering the adder.
  assign w_sample  = ACC_W'(bus.in_data);

  // clear masks in_ready so a sample offered alongside an abort is refused.
  assign w_inReady = (r_state == ACCUM) && !bus.clear;
  assign w_accept  = bus.in_valid && w_inReady;
  assign w_last    = (r_cnt == LAST_CNT);
  assign w_release = (r_state == HOLD) && bus.out_ready;

  sat_add #(
    .W(ACC_W)
  ) u_satAdd (
    .i_a     (r_acc),
    .i_b     (w_sample),
    .o_sum   (w_sum),
    .o_clamp (w_clamp)
  );

  // State register of the block FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ACCUM;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next state: finish a block on its last accepted sample, return once the
  // result is taken; clear overrides both and always lands in ACCUM.
  always_comb begin
    w_nextState = r_state;
    if (bus.clear) begin
      w_nextState = ACCUM;
    end else begin
      case (r_state)
        ACCUM:   if (w_accept && w_last) w_nextState = HOLD;
        HOLD:    if (bus.out_ready) w_nextState = ACCUM;
        default: w_nextState = ACCUM;
      endcase
    end
  end

  // Datapath. The final sample goes straight into the output registers so
  // the result is visible on the same edge out_valid rises; the running
  // accumulator is wiped when the result leaves (or on clear), which keeps
  // the next block from starting before the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_cnt    <= '0;
      r_ovf    <= 1'b0;
      r_outSum <= '0;
      r_outOvf <= 1'b0;
    end else if (bus.clear) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (w_accept) begin
      if (w_last) begin
        r_outSum <= w_sum;
        r_outOvf <= r_ovf | w_clamp;
      end else begin
        r_acc <= w_sum;
        r_cnt <= r_cnt + 1'b1;
        r_ovf <= r_ovf | w_clamp;
      end
    end else if (w_release) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end
  end

  assign bus.in_ready  = w_inReady;
  assign bus.out_valid = (r_state == HOLD);
  assign bus.out_sum   = r_outSum;
  assign bus.out_ovf   = r_outOvf;

endmodule
